// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display arbiter.
// Segment patterns are active-low {g,f,e,d,c,b,a}, and digit enables are active-low.
package seg_pkg;

  // Hex glyphs 0..F
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  // All segments dark / all digits disabled
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Digit enable per scan index; index 0 is the leftmost digit
  localparam logic [3:0] AN_IDX0 = 4'b0111;
  localparam logic [3:0] AN_IDX1 = 4'b1011;
  localparam logic [3:0] AN_IDX2 = 4'b1101;
  localparam logic [3:0] AN_IDX3 = 4'b1110;

  // Arbiter ownership states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Digit enable pattern for a scan index
  function automatic logic [3:0] an_for_index(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      2'd0:    an = AN_IDX0;
      2'd1:    an = AN_IDX1;
      2'd2:    an = AN_IDX2;
      default: an = AN_IDX3;
    endcase
    return an;
  endfunction

  // Nibble shown at a scan index; index 0 takes the most significant nibble
  function automatic logic [3:0] nibble_for_index(input logic [15:0] value,
                                                  input logic [1:0]  idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = value[15:12];
      2'd1:    nib = value[11:8];
      2'd2:    nib = value[7:4];
      default: nib = value[3:0];
    endcase
    return nib;
  endfunction

  // Blank flag for a scan index; bit 3 belongs to the leftmost digit
  function automatic logic blank_for_index(input logic [3:0] blank,
                                           input logic [1:0] idx);
    logic b;
    case (idx)
      2'd0:    b = blank[3];
      2'd1:    b = blank[2];
      2'd2:    b = blank[1];
      default: b = blank[0];
    endcase
    return b;
  endfunction

  // One-hot grant vector for an ownership state
  function automatic logic [1:0] grant_for_state(input arb_state_e st);
    logic [1:0] g;
    case (st)
      OWN0:    g = 2'b01;
      OWN1:    g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to active-low 7-segment pattern decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Look up the glyph for the nibble
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_arbiter.sv
// Two-requester owner of a 4-digit multiplexed 7-segment display.
// A free-running prescaler produces the scan tick; ownership is decided only
// at frame boundaries (the tick that wraps the digit index from 3 back to 0),
// with round-robin tie breaking and a minimum hold before preemption.
// The owner's value and blank mask are latched once per frame so a frame
// never mixes old and new data.
module seg_scan_arbiter
  import seg_pkg::*;
#(
  parameter int DIV_W       = 17,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [3:0]  blank0,
  input  logic [3:0]  blank1,
  output logic [1:0]  grant,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam logic [3:0] HOLD_MAX = 4'(HOLD_FRAMES);

  // Timing chain
  logic [DIV_W-1:0] prescaler_q, prescaler_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic             tick;
  logic             frame_tick;

  // Arbiter state
  arb_state_e state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       last_q, last_d;

  // Per-frame latched owner data
  logic [15:0] data_q, data_d;
  logic [3:0]  blank_q, blank_d;

  // Registered pins
  logic [1:0] grant_q, grant_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;

  // Decode path for the slot about to be shown
  logic [3:0] show_nibble;
  logic [6:0] show_seg;

  assign tick       = &prescaler_q;
  assign frame_tick = tick && (digit_idx_q == 2'd3);

  // Advance the prescaler every cycle and the scan index on each tick
  always_comb begin
    prescaler_d = prescaler_q + DIV_W'(1);
    digit_idx_d = digit_idx_q;
    if (tick) begin
      digit_idx_d = digit_idx_q + 2'd1;
    end
  end

  // Ownership decision at frame boundaries, including hold and round-robin bookkeeping
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (req == 2'b11) begin
            state_d = last_q ? OWN0 : OWN1;
          end else if (req[0]) begin
            state_d = OWN0;
          end else if (req[1]) begin
            state_d = OWN1;
          end
        end
        OWN0: begin
          if (!req[0]) begin
            state_d = req[1] ? OWN1 : IDLE;
          end else if ((hold_q == HOLD_MAX) && req[1]) begin
            state_d = OWN1;
          end
        end
        OWN1: begin
          if (!req[1]) begin
            state_d = req[0] ? OWN0 : IDLE;
          end else if ((hold_q == HOLD_MAX) && req[0]) begin
            state_d = OWN0;
          end
        end
        default: state_d = IDLE;
      endcase

      if (state_d == IDLE) begin
        hold_d = 4'd0;
      end else if (state_d != state_q) begin
        hold_d = 4'd1;
        last_d = (state_d == OWN1);
      end else if (hold_q < HOLD_MAX) begin
        hold_d = hold_q + 4'd1;
      end
    end
  end

  // Capture the incoming owner's value and blank mask at each frame boundary
  always_comb begin
    data_d  = data_q;
    blank_d = blank_q;
    if (frame_tick) begin
      case (state_d)
        OWN0: begin
          data_d  = data0;
          blank_d = blank0;
        end
        OWN1: begin
          data_d  = data1;
          blank_d = blank1;
        end
        default: begin
          data_d  = 16'h0000;
          blank_d = 4'h0;
        end
      endcase
    end
  end

  assign show_nibble = nibble_for_index(data_d, digit_idx_d);

  seg_hex_decode u_hex_decode (
    .nibble (show_nibble),
    .seg    (show_seg)
  );

  // Compute the pins for the next slot; they only change on a tick
  always_comb begin
    grant_d = grant_q;
    seg_d   = seg_q;
    an_d    = an_q;
    if (tick) begin
      grant_d = grant_for_state(state_d);
      if ((state_d == IDLE) || blank_for_index(blank_d, digit_idx_d)) begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
      end else begin
        seg_d = show_seg;
        an_d  = an_for_index(digit_idx_d);
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= 4'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  // Prescaler, scan index and frame latch registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler_q <= '0;
      digit_idx_q <= 2'd0;
      data_q      <= 16'h0000;
      blank_q     <= 4'h0;
    end else begin
      prescaler_q <= prescaler_d;
      digit_idx_q <= digit_idx_d;
      data_q      <= data_d;
      blank_q     <= blank_d;
    end
  end

  // Output pin registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q <= 2'b00;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
    end else begin
      grant_q <= grant_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign grant = grant_q;
  assign seg   = seg_q;
  assign an    = an_q;
  assign dp    = 1'b1;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Scoreboard bench for seg_scan_arbiter with a fast prescaler.
// A reference model, stepped on every rising edge, predicts the pin values and
// queues them; a monitor on the falling edge pops and compares.
module tb_seg_scan_arbiter;

  localparam int DIV_W = 2;
  localparam int HOLD  = 2;
  localparam int TICK_PERIOD = 1 << DIV_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req;
  logic [15:0] data0, data1;
  logic [3:0]  blank0, blank1;
  logic [1:0]  grant;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  int checks   = 0;
  int failures = 0;

  logic [13:0] expect_q [$];

  // Reference model state
  int          m_cycle;
  int          m_idx;
  int          m_owner;
  int          m_held;
  int          m_last;
  logic [15:0] m_data;
  logic [3:0]  m_blank;
  logic [1:0]  m_grant;
  logic [6:0]  m_seg;
  logic [3:0]  m_an;

  logic [6:0] hex_table [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 clk = ~clk;

  seg_scan_arbiter #(
    .DIV_W       (DIV_W),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .data0  (data0),
    .data1  (data1),
    .blank0 (blank0),
    .blank1 (blank1),
    .grant  (grant),
    .seg    (seg),
    .an     (an),
    .dp     (dp)
  );

  // Compare one observed pin vector against its expectation
  task automatic checkOutput(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20) begin
        $display("[TB] FAIL %s t=%0t actual grant=%b seg=%b an=%b dp=%b required grant=%b seg=%b an=%b dp=%b",
                 name, $time, act[13:12], act[11:5], act[4:1], act[0],
                 exp[13:12], exp[11:5], exp[4:1], exp[0]);
      end
    end
  endtask

  // Ownership rules applied once per frame
  task automatic frameDecision();
    int nxt;
    int other;
    nxt = m_owner;
    if (m_owner < 0) begin
      if (req == 2'b11)      nxt = 1 - m_last;
      else if (req == 2'b01) nxt = 0;
      else if (req == 2'b10) nxt = 1;
    end else begin
      other = 1 - m_owner;
      if (!req[m_owner])                      nxt = req[other] ? other : -1;
      else if (m_held >= HOLD && req[other])  nxt = other;
    end
    if (nxt != m_owner) begin
      m_owner = nxt;
      if (nxt >= 0) begin
        m_held = 1;
        m_last = nxt;
      end else begin
        m_held = 0;
      end
    end else if (m_owner >= 0 && m_held < HOLD) begin
      m_held++;
    end
    if (m_owner == 0) begin
      m_data  = data0;
      m_blank = blank0;
    end else if (m_owner == 1) begin
      m_data  = data1;
      m_blank = blank1;
    end else begin
      m_data  = 16'h0;
      m_blank = 4'h0;
    end
  endtask

  // One clock of the reference model; queues the pins expected after this edge
  task automatic modelStep();
    logic [3:0] nib;
    if (!rst) begin
      m_cycle = 0;
      m_idx   = 0;
      m_owner = -1;
      m_held  = 0;
      m_last  = 1;
      m_data  = 16'h0;
      m_blank = 4'h0;
      m_grant = 2'b00;
      m_seg   = 7'h7F;
      m_an    = 4'hF;
    end else begin
      if (m_cycle % TICK_PERIOD == TICK_PERIOD - 1) begin
        if (m_idx == 3) frameDecision();
        m_idx   = (m_idx + 1) % 4;
        m_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        nib     = 4'((m_data >> (12 - 4 * m_idx)) & 16'hF);
        if (m_owner < 0 || m_blank[3 - m_idx]) begin
          m_seg = 7'h7F;
          m_an  = 4'hF;
        end else begin
          m_seg = hex_table[nib];
          m_an  = ~(4'b1000 >> m_idx);
        end
      end
      m_cycle++;
    end
    expect_q.push_back({m_grant, m_seg, m_an, 1'b1});
  endtask

  // Model process
  initial begin
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  // Monitor process
  initial begin
    logic [13:0] exp;
    forever begin
      @(negedge clk);
      if (expect_q.size() > 0) begin
        exp = expect_q.pop_front();
        checkOutput("pins", {grant, seg, an, dp}, exp);
      end
    end
  end

  // Drive one input pattern and hold it for a number of cycles
  task automatic applyStimulus(input logic [1:0] r, input logic [15:0] d0, input logic [15:0] d1,
                               input logic [3:0] b0, input logic [3:0] b1, input int cycles);
    @(negedge clk);
    req    = r;
    data0  = d0;
    data1  = d1;
    blank0 = b0;
    blank1 = b1;
    repeat (cycles) @(negedge clk);
  endtask

  // Assert reset between clock edges and confirm the pins clear immediately
  task automatic applyAsyncReset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 checkOutput("async_reset", {grant, seg, an, dp}, {2'b00, 7'h7F, 4'hF, 1'b1});
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    req    = 2'b00;
    data0  = 16'h0;
    data1  = 16'h0;
    blank0 = 4'h0;
    blank1 = 4'h0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    $display("[TB] idle after reset");
    applyStimulus(2'b00, 16'h0, 16'h0, 4'h0, 4'h0, 40);

    $display("[TB] single requester 0");
    applyStimulus(2'b01, 16'h1234, 16'h0, 4'h0, 4'h0, 48);

    $display("[TB] data change mid-frame");
    applyStimulus(2'b01, 16'hABCD, 16'h0, 4'h0, 4'h0, 40);

    $display("[TB] both requesting, alternation");
    applyStimulus(2'b00, 16'hABCD, 16'h00F0, 4'h0, 4'h8, 32);
    applyStimulus(2'b11, 16'hABCD, 16'h00F0, 4'h0, 4'h8, 160);

    $display("[TB] owner drop without hold wait");
    applyStimulus(2'b00, 16'h5678, 16'h9E0F, 4'h0, 4'h0, 32);
    applyStimulus(2'b11, 16'h5678, 16'h9E0F, 4'h0, 4'h0, 30);
    applyStimulus(2'b10, 16'h5678, 16'h9E0F, 4'h0, 4'h0, 40);

    $display("[TB] async reset while owner 1");
    applyAsyncReset();
    applyStimulus(2'b11, 16'h2468, 16'h1357, 4'h2, 4'h1, 64);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 150; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                    4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    $urandom_range(3, 70));
      if (i == 75) applyAsyncReset();
    end
    applyStimulus(2'b00, 16'h0, 16'h0, 4'h0, 4'h0, 40);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
